alu_exec_stage: RTL
===================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset; one clock domain only.
REQ-003 in_valid  input  1  upstream (decode) presents an operation.
REQ-004 in_ready  output  1  stage can accept an operation this cycle.
REQ-005 in_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA; 10-15 illegal.
REQ-006 in_a  input  64  operand A.
REQ-007 in_b  input  64  operand B; for shifts, in_b[5:0] is the shift amount.
REQ-008 in_tag  input  5  destination register tag, passed through unchanged.
REQ-009 out_valid  output  1  result available to writeback.
REQ-010 out_ready  input  1  writeback accepts result this cycle.
REQ-011 out_result  output  64  operation result.
REQ-012 out_tag  output  5  tag of the operation in out_result.
REQ-013 out_zf  output  1  1 when out_result == 0.
REQ-014 out_illegal  output  1  1 when the delivered op was 10-15.

Function
REQ-015 Transfer in = in_valid & in_ready at rising edge; transfer out = out_valid & out_ready at rising edge.
REQ-016 FSM states IDLE, SHIFT, DONE; out_valid = (state == DONE); in_ready = (state == IDLE) | (state == DONE & out_ready).
REQ-017 IDLE: on transfer in, latch op/operands/tag; non-shift op, or shift with amount 0 -> DONE with final result; shift with amount k > 0 -> SHIFT with counter = k.
REQ-018 SHIFT: each cycle shift the working register one bit (SLL left zero-fill, SRL right zero-fill, SRA right sign-fill), decrement counter; at counter == 1 the shift completes and state -> DONE on that edge.
REQ-019 Latency: non-shift and zero-amount ops -> out_valid in cycle after acceptance edge; shift by k -> out_valid k cycles after acceptance edge (k in 1..63).
REQ-020 ADD/SUB: 64-bit modulo 2^64, carry/overflow discarded.
REQ-021 SLT: 64-bit two's-complement signed compare, result 64'd1 if A < B else 64'd0.
REQ-022 SLTU: unsigned compare, same 0/1 encoding.
REQ-023 Illegal op: out_result = 0, out_illegal = 1, out_zf = 1, latency as non-shift.
REQ-024 DONE: out_result/out_tag/out_zf/out_illegal held stable while out_valid & ~out_ready.
REQ-025 DONE with out_ready & in_valid: both transfers occur on the same edge; new op loaded, no bubble.
REQ-026 DONE with out_ready & ~in_valid: state -> IDLE.
REQ-027 in_ready = 0 throughout SHIFT; inputs ignored.
REQ-028 out_zf and out_illegal registered with out_result, never combinational on in_*.

Reset
REQ-029 rst asserted: state -> IDLE immediately, independent of clk.
REQ-030 Reset values: out_valid 0, out_result 0, out_tag 0, out_zf 0, out_illegal 0, shift counter 0; in_ready 1 after reset released.
REQ-031 Reset during SHIFT or DONE discards the in-flight operation; no partial result ever delivered.

Verification
REQ-032 SLT A=-5, B=3, tag 7, out_ready=1 -> next cycle out_valid=1, out_result=1, out_tag=7, out_zf=0.
REQ-033 SLT A=-10, B=-20 -> 0, out_zf=1; SLTU A=-5, B=3 -> 0; SLTU A=3, B=-5 -> 1.
REQ-034 SRA A=0x8000_0000_0000_0000, B=4 -> in_ready low 4 cycles, then out_result=0xF800_0000_0000_0000; SRL same inputs -> 0x0800_0000_0000_0000; SLL by 0 -> A after 1 cycle.
REQ-035 ADD A=10, B=5 with out_ready=0 for 3 cycles -> out_valid held, out_result=15 stable, in_ready=0; raise out_ready with in_valid SUB 10,5 -> result 5 next cycle, no bubble.
REQ-036 SLL A=1, B=63; assert rst at 10th cycle of SHIFT -> out_valid 0, out_result 0 immediately; next ADD 1,1 after release -> 2.
REQ-037 Op 12 with A=B=0xFFFF_FFFF_FFFF_FFFF -> out_result=0, out_illegal=1, out_zf=1.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Single-issue 64-bit ALU execute stage with valid/ready handshakes on both sides.
// Shifts run one bit per cycle in a working register; all other ops finish in one cycle.
module alu_exec_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [63:0] in_a,
   input  logic [63:0] in_b,
   input  logic [4:0]  in_tag,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [4:0]  out_tag,
   output logic        out_zf,
   output logic        out_illegal
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

   state_t      state_q, state_d;
   shift_kind_t kind_q, kind_d;
   logic [63:0] result_q, alu_value, shifted;
   logic [5:0]  count_q;
   logic [4:0]  tag_q;
   logic        zf_q, illegal_q;
   logic        is_shift, start_shift, accept;
   logic [5:0]  shamt;

   assign shamt       = in_b[5:0];
   assign in_ready    = (state_q == IDLE) | ((state_q == DONE) & out_ready);
   assign accept      = in_valid & in_ready;
   assign start_shift = is_shift & (shamt != 6'd0);

   assign out_valid   = (state_q == DONE);
   assign out_result  = result_q;
   assign out_tag     = tag_q;
   assign out_zf      = zf_q;
   assign out_illegal = illegal_q;

   // Shift ops load the unshifted operand; the SHIFT state walks it one bit per cycle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      alu_value = '0;
      is_shift  = 1'b0;
      kind_d    = SK_SLL;
      case (in_op)
         OP_ADD:  alu_value = in_a + in_b;
         OP_SUB:  alu_value = in_a - in_b;
         OP_AND:  alu_value = in_a & in_b;
         OP_OR:   alu_value = in_a | in_b;
         OP_XOR:  alu_value = in_a ^ in_b;
         OP_SLT:  alu_value = {63'd0, $signed(in_a) < $signed(in_b)};
         OP_SLTU: alu_value = {63'd0, in_a < in_b};
         OP_SLL:  begin alu_value = in_a; is_shift = 1'b1; kind_d = SK_SLL; end
         OP_SRL:  begin alu_value = in_a; is_shift = 1'b1; kind_d = SK_SRL; end
         OP_SRA:  begin alu_value = in_a; is_shift = 1'b1; kind_d = SK_SRA; end
         default: alu_value = '0;
      endcase
   end

   always_comb begin
      shifted = result_q;
      case (kind_q)
         SK_SLL:  shifted = {result_q[62:0], 1'b0};
         SK_SRL:  shifted = {1'b0, result_q[63:1]};
         SK_SRA:  shifted = {result_q[63], result_q[63:1]};
         default: shifted = result_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      if (accept) begin
         state_d = start_shift ? SHIFT : DONE;
      end else begin
         case (state_q)
            SHIFT:   if (count_q == 6'd1) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: datapath registers are reset too, so a discarded operation never leaves a visible result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q  <= '0;
         count_q   <= '0;
         tag_q     <= '0;
         zf_q      <= 1'b0;
         illegal_q <= 1'b0;
         kind_q    <= SK_SLL;
      end else if (accept) begin
         result_q  <= alu_value;
         count_q   <= is_shift ? shamt : 6'd0;
         tag_q     <= in_tag;
         zf_q      <= (alu_value == 64'd0);
         illegal_q <= (in_op > OP_SRA);
         kind_q    <= kind_d;
      end else if (state_q == SHIFT) begin
         result_q <= shifted;
         count_q  <= count_q - 6'd1;
         if (count_q == 6'd1) zf_q <= (shifted == 64'd0);
      end
   end

endmodule
